// File: rtl/sha_msg_feeder_pkg.sv
// Shared constants, state encoding and helpers for the SHA message feeder.
package sha_msg_feeder_pkg;

  localparam int SLOT_LEN  = 65;
  localparam int NONCE_W   = 32;
  localparam int HDR_WORDS = 19;

  localparam logic [1:0]  BLK_IDLE = 2'd3;
  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_WORD = 32'h00000280;   // 640-bit message length
  localparam logic [6:0]  SEL_LAST = 7'(SLOT_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLK0,
    ST_BLK1,
    ST_BLK2,
    ST_RESULT
  } state_t;

  // Block index presented to the hash core for a given state.
  function automatic logic [1:0] blk_code(state_t s);
    case (s)
      ST_BLK0: blk_code = 2'd0;
      ST_BLK1: blk_code = 2'd1;
      ST_BLK2: blk_code = 2'd2;
      default: blk_code = BLK_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sha_msg_feeder_if.sv
// Host/core-facing bundle of the feeder: header load, sweep control and core drive.
interface sha_msg_feeder_if;

  logic        hdr_we;
  logic [4:0]  hdr_addr;
  logic [31:0] hdr_data;
  logic [31:0] nonce_start;
  logic [31:0] nonce_end;
  logic        start;
  logic        stop;
  logic [1:0]  block;
  logic [6:0]  select;
  logic [31:0] msg_in;
  logic [31:0] nonce_out;
  logic        result_valid;
  logic        busy;
  logic        done;

  // Feeder side: takes controls, drives the hash core.
  modport master (
    input  hdr_we, hdr_addr, hdr_data, nonce_start, nonce_end, start, stop,
    output block, select, msg_in, nonce_out, result_valid, busy, done
  );

  // Host/core side.
  modport slave (
    output hdr_we, hdr_addr, hdr_data, nonce_start, nonce_end, start, stop,
    input  block, select, msg_in, nonce_out, result_valid, busy, done
  );

endinterface

// File: rtl/sha_msg_feeder_hdr_regfile.sv
// 19 x 32 header store: one write port, one combinational read port. Not reset.
module hdr_regfile
  import sha_msg_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data
);

  logic [31:0] mem [HDR_WORDS];

  // Header word write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (we && (wr_addr < 5'(HDR_WORDS))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (rd_addr < 5'(HDR_WORDS)) ? mem[rd_addr] : 32'd0;

endmodule

// File: rtl/sha_msg_feeder.sv
// Streams header + nonce + padding into the hash core as blocks 0..2, sweeping
// the nonce over an inclusive (possibly wrapping) range.
module sha_msg_feeder
  import sha_msg_feeder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sha_msg_feeder_if.master bus
);

  state_t             state_reg, state_next;
  logic [6:0]         sel_reg, sel_next;
  logic [1:0]         blk_reg, blk_next;
  logic [31:0]        msg_reg, msg_next;
  logic [NONCE_W-1:0] nonce_reg, nonce_next;
  logic [NONCE_W-1:0] nonce_end_reg, nonce_end_next;
  logic               rv_reg, rv_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic               accept_start;
  logic               hdr_wr;
  logic [4:0]         rd_addr;
  logic [31:0]        rd_data;

  // stop beats start in IDLE; header is frozen while a sweep runs.
  assign accept_start = (state_reg == ST_IDLE) && bus.start && !bus.stop;
  assign hdr_wr       = bus.hdr_we && !busy_reg && !accept_start;

  hdr_regfile u_hdr (
    .clk     (clk),
    .we      (hdr_wr),
    .wr_addr (bus.hdr_addr),
    .wr_data (bus.hdr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state logic: block sequencing, select counter and nonce stepping.
  always_comb begin
    state_next     = state_reg;
    sel_next       = 7'd0;
    nonce_next     = nonce_reg;
    nonce_end_next = nonce_end_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept_start) begin
          state_next     = ST_BLK0;
          nonce_next     = bus.nonce_start;
          nonce_end_next = bus.nonce_end;
          busy_next      = 1'b1;
        end
      end
      ST_BLK0: begin
        if (sel_reg == SEL_LAST) state_next = ST_BLK1;
        else                     sel_next   = sel_reg + 7'd1;
      end
      ST_BLK1: begin
        if (sel_reg == SEL_LAST) state_next = ST_BLK2;
        else                     sel_next   = sel_reg + 7'd1;
      end
      ST_BLK2: begin
        if (sel_reg == SEL_LAST) state_next = ST_RESULT;
        else                     sel_next   = sel_reg + 7'd1;
      end
      ST_RESULT: begin
        if (nonce_reg == nonce_end_reg) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          state_next = ST_BLK0;
          nonce_next = nonce_reg + 1'b1;   // wraps naturally at 2^32
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort: silent return to IDLE, no result or done strobe.
    if ((state_reg != ST_IDLE) && bus.stop) begin
      state_next = ST_IDLE;
      sel_next   = 7'd0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      nonce_next = nonce_reg;
    end
  end

  assign blk_next = blk_code(state_next);
  assign rv_next  = (state_next == ST_RESULT);

  // Header read address for the word that goes out with the upcoming select.
  always_comb begin
    rd_addr = 5'd0;
    if (state_next == ST_BLK0 && sel_next < 7'd16) begin
      rd_addr = sel_next[4:0];
    end else if (state_next == ST_BLK1 && sel_next < 7'd3) begin
      rd_addr = 5'd16 + sel_next[4:0];
    end
  end

  // Message word mux, evaluated against the upcoming block/select so msg_in
  // and select change on the same edge.
  always_comb begin
    msg_next = 32'd0;
    if (state_next == ST_BLK0) begin
      if (sel_next < 7'd16) msg_next = rd_data;
    end else if (state_next == ST_BLK1) begin
      case (sel_next)
        7'd0, 7'd1, 7'd2: msg_next = rd_data;
        7'd3:             msg_next = nonce_next;
        7'd4:             msg_next = PAD_WORD;
        7'd15:            msg_next = LEN_WORD;
        default:          msg_next = 32'd0;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= 7'd0;
      blk_reg       <= BLK_IDLE;
      msg_reg       <= 32'd0;
      nonce_reg     <= '0;
      nonce_end_reg <= '0;
      rv_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      blk_reg       <= blk_next;
      msg_reg       <= msg_next;
      nonce_reg     <= nonce_next;
      nonce_end_reg <= nonce_end_next;
      rv_reg        <= rv_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign bus.block        = blk_reg;
  assign bus.select       = sel_reg;
  assign bus.msg_in       = msg_reg;
  assign bus.nonce_out    = nonce_reg;
  assign bus.result_valid = rv_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;

endmodule
